// File: rtl/action_scheduler.sv
// action_scheduler: merges button pulses, gravity and garbage-bar timers into
// one prioritised stream of action codes, issued over valid/ready from a
// show-ahead FIFO. Optional garbage bar: define GARBAGE_BAR_EN.
module action_scheduler #(
    parameter int QSIZE     = 16,
    parameter int DOWN_TICK = 50_000_000,
    parameter int BAR_TICK  = 1_000_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_over,
    input  logic                    i_btn_left,
    input  logic                    i_btn_right,
    input  logic                    i_btn_down,
    input  logic                    i_btn_drop,
    input  logic                    i_btn_hold,
    input  logic                    i_btn_rot,
    input  logic                    i_btn_rotrev,
    output logic                    o_act_valid,
    output logic [7:0]              o_act_code,
    input  logic                    i_act_ready,
    output logic [$clog2(QSIZE):0]  o_q_count,
    output logic                    o_dropped,
    output logic                    o_running,
    output logic                    o_game_over
);
    localparam int AW = $clog2(QSIZE);
    localparam int CW = AW + 1;
    localparam int GW = (DOWN_TICK > 1) ? $clog2(DOWN_TICK) : 1;

    // state_type action codes
    localparam logic [7:0] C_NONE = 8'd0, C_INIT = 8'd1, C_DOWN = 8'd2,
                           C_LEFT = 8'd3, C_RIGHT = 8'd4, C_DROP = 8'd5,
                           C_HOLD = 8'd6, C_ROT = 8'd7, C_ROTREV = 8'd8,
                           C_BAR = 8'd9;

    // Pending-flag bit positions; a higher index wins arbitration.
    localparam int P_RIGHT = 0, P_LEFT = 1, P_ROTREV = 2, P_ROT = 3,
                   P_HOLD = 4, P_DROP = 5, P_DOWN = 6, P_BAR = 7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t           r_state;
    logic             r_running, r_game_over;
    logic             w_halt, w_run_act;
    logic [GW-1:0]    r_grav;
    logic             w_grav_wrap, w_bar_wrap;
    logic [7:0]       r_pend, w_req, w_grant, w_push_code;
    logic             r_dropped;
    logic             w_pop, w_push, w_can_push;
    logic [7:0]       r_mem [QSIZE];
    logic [AW-1:0]    r_rd, r_wr;
    logic [CW-1:0]    r_count;
    logic             r_valid;

    function automatic logic [7:0] f_code(input int idx);
        case (idx)
            P_BAR:    f_code = C_BAR;
            P_DOWN:   f_code = C_DOWN;
            P_DROP:   f_code = C_DROP;
            P_HOLD:   f_code = C_HOLD;
            P_ROT:    f_code = C_ROT;
            P_ROTREV: f_code = C_ROTREV;
            P_LEFT:   f_code = C_LEFT;
            default:  f_code = C_RIGHT;
        endcase
    endfunction

    // start beats over; over only matters while running
    assign w_halt    = i_over & ~i_start & (r_state == S_RUN);
    assign w_run_act = (r_state == S_RUN) & ~i_start & ~i_over;

    // Game FSM with registered status outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_running   <= 1'b0;
            r_game_over <= 1'b0;
        end else if (i_start) begin
            r_state     <= S_RUN;
            r_running   <= 1'b1;
            r_game_over <= 1'b0;
        end else if (w_halt) begin
            r_state     <= S_HALT;
            r_running   <= 1'b0;
            r_game_over <= 1'b1;
        end
    end

    assign w_grav_wrap = w_run_act & (r_grav == GW'(DOWN_TICK - 1));

    // Gravity timer: free-runs in RUN, frozen otherwise, cleared on (re)start
    always_ff @(posedge i_clk) begin
        if (i_reset | i_start)
            r_grav <= '0;
        else if (w_run_act)
            r_grav <= w_grav_wrap ? '0 : r_grav + GW'(1);
    end

`ifdef GARBAGE_BAR_EN
    localparam int BW = (BAR_TICK > 1) ? $clog2(BAR_TICK) : 1;
    logic [BW-1:0] r_bar;

    assign w_bar_wrap = w_run_act & (r_bar == BW'(BAR_TICK - 1));

    // Garbage-bar timer: same behaviour as gravity with its own period
    always_ff @(posedge i_clk) begin
        if (i_reset | i_start)
            r_bar <= '0;
        else if (w_run_act)
            r_bar <= w_bar_wrap ? '0 : r_bar + BW'(1);
    end
`else
    // no garbage bar: the BAR request can never fire
    assign w_bar_wrap = 1'b0 & (BAR_TICK > 0);
`endif

    // Collect this cycle's requests; pulses outside RUN are discarded
    always_comb begin
        w_req = '0;
        if (w_run_act) begin
            w_req[P_BAR]    = w_bar_wrap;
            w_req[P_DOWN]   = i_btn_down | w_grav_wrap;
            w_req[P_DROP]   = i_btn_drop;
            w_req[P_HOLD]   = i_btn_hold;
            w_req[P_ROT]    = i_btn_rot;
            w_req[P_ROTREV] = i_btn_rotrev;
            w_req[P_LEFT]   = i_btn_left;
            w_req[P_RIGHT]  = i_btn_right;
        end
    end

    assign w_pop      = r_valid & i_act_ready;
    assign w_can_push = (r_count != CW'(QSIZE)) | w_pop;

    // Grant the highest-priority pending flag when a slot is free
    always_comb begin
        w_grant     = '0;
        w_push_code = C_NONE;
        if (w_run_act & w_can_push) begin
            for (int i = 0; i < 8; i++) begin
                if (r_pend[i]) begin
                    w_grant     = 8'(1) << i;
                    w_push_code = f_code(i);
                end
            end
        end
    end

    assign w_push = |w_grant;

    // Pending flags: a re-pulse on an un-granted flag is merged and flagged
    always_ff @(posedge i_clk) begin
        if (i_reset | i_start) begin
            r_pend    <= '0;
            r_dropped <= 1'b0;
        end else if (w_halt) begin
            r_pend    <= '0;
        end else if (w_run_act) begin
            r_pend <= (r_pend & ~w_grant) | w_req;
            if (|(w_req & r_pend & ~w_grant))
                r_dropped <= 1'b1;
        end
    end

    // Show-ahead action FIFO; (re)start leaves INIT as the only entry
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (i_start) begin
            r_mem[0] <= C_INIT;
            r_rd     <= '0;
            r_wr     <= AW'(1);
            r_count  <= CW'(1);
            r_valid  <= 1'b1;
        end else if (w_halt) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_push_code;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10: begin
                    r_count <= r_count + CW'(1);
                    r_valid <= 1'b1;
                end
                2'b01: begin
                    r_count <= r_count - CW'(1);
                    r_valid <= (r_count != CW'(1));
                end
                default: ;
            endcase
        end
    end

    assign o_act_valid = r_valid;
    assign o_act_code  = r_valid ? r_mem[r_rd] : C_NONE;
    assign o_q_count   = r_count;
    assign o_dropped   = r_dropped;
    assign o_running   = r_running;
    assign o_game_over = r_game_over;

endmodule

// File: tb/tb_action_scheduler.sv
// tb_action_scheduler: directed stimulus, queue-based reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_action_scheduler;
    localparam int QS = 16;
    localparam int DT = 10;
    localparam int BT = 100;
`ifdef GARBAGE_BAR_EN
    localparam bit BAR_EN = 1'b1;
`else
    localparam bit BAR_EN = 1'b0;
`endif
    localparam logic [7:0] INIT = 1, DOWN = 2, LEFT = 3, RIGHT = 4, DROP = 5,
                           HOLD = 6, ROT = 7, ROTREV = 8, BAR = 9;

    logic       clk = 0, reset, start, over, ready;
    logic       b_left, b_right, b_down, b_drop, b_hold, b_rot, b_rotrev;
    logic       valid, dropped, running, gover;
    logic [7:0] code;
    logic [4:0] qcnt;

    int n_cmp = 0, n_err = 0, rel = 0;

    action_scheduler #(.QSIZE(QS), .DOWN_TICK(DT), .BAR_TICK(BT)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_over(over),
        .i_btn_left(b_left), .i_btn_right(b_right), .i_btn_down(b_down),
        .i_btn_drop(b_drop), .i_btn_hold(b_hold), .i_btn_rot(b_rot),
        .i_btn_rotrev(b_rotrev), .o_act_valid(valid), .o_act_code(code),
        .i_act_ready(ready), .o_q_count(qcnt), .o_dropped(dropped),
        .o_running(running), .o_game_over(gover)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending requests kept in priority order; the queue holds issued codes.
    logic [7:0] prio_code [8] = '{BAR, DOWN, DROP, HOLD, ROT, ROTREV, LEFT, RIGHT};
    bit         m_pend [8];
    logic [7:0] m_q [$];
    int         m_state = 0;   // 0 idle, 1 run, 2 halt
    bit         m_dropped = 0, m_init = 0;
    int         m_tick = 0;

    always @(posedge clk) begin
        bit pulse [8];
        bit pop, push;
        int pick;
        if (reset) begin
            m_init = 1; m_state = 0; m_q.delete(); m_dropped = 0; m_tick = 0;
            foreach (m_pend[i]) m_pend[i] = 0;
        end else if (start) begin
            m_state = 1; m_q.delete(); m_q.push_back(INIT); m_dropped = 0; m_tick = 0;
            foreach (m_pend[i]) m_pend[i] = 0;
        end else if (over && m_state == 1) begin
            m_state = 2; m_q.delete();
            foreach (m_pend[i]) m_pend[i] = 0;
        end else if (m_state == 1) begin
            m_tick++;
            pulse[0] = BAR_EN && (m_tick % BT == 0);
            pulse[1] = b_down || (m_tick % DT == 0);
            pulse[2] = b_drop;  pulse[3] = b_hold;   pulse[4] = b_rot;
            pulse[5] = b_rotrev; pulse[6] = b_left;  pulse[7] = b_right;
            pop  = (m_q.size() > 0) && ready;
            pick = -1;
            for (int i = 0; i < 8; i++) if (m_pend[i] && pick < 0) pick = i;
            push = (pick >= 0) && (m_q.size() < QS || pop);
            if (push) m_pend[pick] = 0;
            for (int i = 0; i < 8; i++)
                if (pulse[i]) begin
                    if (m_pend[i]) m_dropped = 1;
                    m_pend[i] = 1;
                end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(prio_code[pick]);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_init) begin
            chk("m_valid",   valid,   m_q.size() > 0);
            chk("m_code",    code,    (m_q.size() > 0) ? m_q[0] : 8'd0);
            chk("m_count",   qcnt,    m_q.size());
            chk("m_dropped", dropped, m_dropped);
            chk("m_running", running, m_state == 1);
            chk("m_over",    gover,   m_state == 2);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #2; rel++;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_valid"}, valid, 0);
        chk({p, "_code"}, code, 0);
        chk({p, "_count"}, qcnt, 0);
        chk({p, "_dropped"}, dropped, 0);
        chk({p, "_running"}, running, 0);
        chk({p, "_over"}, gover, 0);
    endtask

    initial begin
        int nleft, ndown, nbar, nbd, first_down;
        logic [7:0] last;
        reset = 1; start = 0; over = 0; ready = 0;
        b_left = 0; b_right = 0; b_down = 0; b_drop = 0; b_hold = 0; b_rot = 0; b_rotrev = 0;
        tick(); tick();
        chk_reset_vals("rst");

        // pulses while idle are ignored
        reset = 0; b_left = 1; tick(); b_left = 0; tick();
        chk("idle_count", qcnt, 0);
        chk("idle_dropped", dropped, 0);

        // start -> INIT, drained in one accepted cycle
        start = 1; ready = 1; tick(); start = 0; rel = 0;
        chk("start_running", running, 1);
        chk("start_valid", valid, 1);
        chk("start_code", code, INIT);
        chk("start_count", qcnt, 1);
        tick();
        chk("init_drain_count", qcnt, 0);
        chk("init_drain_valid", valid, 0);

        // priority: three buttons in one cycle
        ready = 0; b_left = 1; b_rot = 1; b_drop = 1; tick();
        b_left = 0; b_rot = 0; b_drop = 0;
        tick(); tick(); tick();
        chk("prio_count", qcnt, 3);
        chk("prio_first", code, DROP);
        ready = 1; tick();
        chk("prio_second", code, ROT);
        tick();
        chk("prio_third", code, LEFT);
        tick();
        chk("prio_empty", valid, 0);
        chk("prio_dropped", dropped, 0);

        // fill the FIFO with DOWN, then merge two LEFT pulses
        ready = 0; b_down = 1;
        while (rel < 24) tick();
        b_down = 0; tick();
        chk("full_count", qcnt, 16);
        chk("full_dropped", dropped, 0);
        b_left = 1; tick(); tick(); b_left = 0;
        chk("merge_dropped", dropped, 1);
        chk("merge_count", qcnt, 16);
        ready = 1; nleft = 0;
        while (rel < 52) begin
            if (valid && code == LEFT) nleft++;
            tick();
        end
        chk("merge_one_left", nleft, 1);
        while (rel < 54) tick();

        // gravity (and bar) cadence with ready held high
        ndown = 0; nbar = 0; nbd = 0; first_down = -1; last = 0;
        while (rel < 254) begin
            if (valid) begin
                if (code == DOWN) begin
                    ndown++;
                    if (first_down < 0) first_down = rel + 1;
                    if (last == BAR) nbd++;
                end
                if (code == BAR) nbar++;
                last = code;
            end
            tick();
        end
        chk("grav_count", ndown, 20);
        chk("grav_first_edge", first_down, 62);
        chk("bar_count", nbar, BAR_EN ? 2 : 0);
        chk("bar_before_down", nbd, BAR_EN ? 2 : 0);

        // over with five entries queued
        ready = 0; b_drop = 1; b_hold = 1; b_rot = 1; b_rotrev = 1; b_left = 1; tick();
        b_drop = 0; b_hold = 0; b_rot = 0; b_rotrev = 0; b_left = 0;
        while (rel < 260) tick();
        chk("pre_over_count", qcnt, 5);
        chk("pre_over_code", code, DROP);
        over = 1; tick(); over = 0;
        chk("over_valid", valid, 0);
        chk("over_count", qcnt, 0);
        chk("over_gover", gover, 1);
        chk("over_running", running, 0);
        b_left = 1; b_down = 1; tick(); tick(); b_left = 0; b_down = 0; tick();
        chk("halt_ignore_count", qcnt, 0);
        chk("halt_dropped_sticky", dropped, 1);

        // restart from HALT
        start = 1; tick(); start = 0; rel = 0;
        chk("restart_running", running, 1);
        chk("restart_gover", gover, 0);
        chk("restart_code", code, INIT);
        chk("restart_count", qcnt, 1);
        chk("restart_dropped", dropped, 0);
        tick(); tick();
        chk("restart_hold_count", qcnt, 1);
        chk("restart_hold_code", code, INIT);
        ready = 1; tick();
        chk("restart_drain", valid, 0);
        ready = 0; b_left = 1; tick(); b_left = 0; tick(); tick();
        chk("pre_so_count", qcnt, 1);
        chk("pre_so_code", code, LEFT);

        // start and over together: start wins
        start = 1; over = 1; tick(); start = 0; over = 0; rel = 0;
        chk("so_running", running, 1);
        chk("so_gover", gover, 0);
        chk("so_count", qcnt, 1);
        chk("so_code", code, INIT);

        // reset mid-RUN
        reset = 1; tick();
        chk_reset_vals("midrst");
        reset = 0; tick();
        chk("post_rst_running", running, 0);
        chk("post_rst_valid", valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
